// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: in-order fetches to a variable-latency imem, buffered {instr, pc+4} toward IF/ID.
// Optional macro IFQ_BYPASS_EN: an empty queue forwards a response to the outputs in the same cycle.
module ifetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_incr,
    input  logic        out_ready
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          OW      = $clog2(MAX_OUTST + 1);
    localparam logic [31:0] DEPTH_U = DEPTH;
    localparam logic [31:0] MAXO_U  = MAX_OUTST;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pcinc_mem [DEPTH];

    logic          grant;
    logic          resp_run;
    logic          push;
    logic          pop;
    logic          bypass_hit;
    logic          bypass_take;
    logic [OW-1:0] stale;

    // Requests depend only on registered state, so redirect never reaches imem_req combinationally.
    always_comb begin
        imem_req  = rst && (state_q == RUN) && (32'(outst_q) < MAXO_U)
                    && ((32'(count_q) + 32'(outst_q)) < DEPTH_U);
        imem_addr = fetch_pc_q;
    end

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = rst && (count_q == '0) && (state_q == RUN) && imem_rvalid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign grant       = imem_req & imem_gnt;
    assign resp_run    = imem_rvalid && (state_q == RUN);
    assign bypass_take = bypass_hit & out_ready;
    assign push        = resp_run && !bypass_take && !redirect_valid;
    assign pop         = (count_q != '0) && out_ready && !redirect_valid;
    // Responses already owed after this cycle; all of them are stale if a redirect happens now.
    assign stale       = outst_q + OW'(grant) - OW'(imem_rvalid);

    // Output process
    always_comb begin
        out_valid   = 1'b0;
        out_instr   = 32'h0;
        out_pc_incr = 32'h0;
        if (bypass_hit) begin
            out_valid   = 1'b1;
            out_instr   = imem_rdata;
            out_pc_incr = resp_pc_q + 32'd4;
        end else if (count_q != '0) begin
            out_valid   = 1'b1;
            out_instr   = instr_mem[rd_ptr_q];
            out_pc_incr = pcinc_mem[rd_ptr_q];
        end
    end

    // Datapath next-state: redirect overrides push, pop and the pc advance from a grant.
    always_comb begin
        fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = resp_run ? resp_pc_q + 32'd4 : resp_pc_q;
        outst_d    = stale;
        discard_d  = discard_q;
        if ((state_q == FLUSH) && imem_rvalid) begin
            discard_d = discard_q - OW'(1);
        end
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            if (state_q == RUN) begin
                discard_d = stale;
            end
        end
    end

    // FSM next-state process
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (redirect_valid && (stale != '0)) state_d = FLUSH;
            FLUSH:   if (discard_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pcinc_mem[wr_ptr_q] <= resp_pc_q + 32'd4;
        end
    end

endmodule
